// File: rtl/ddr_frame_rd_pkg.sv
// Shared constants and control-state encoding
// for the DDR-side frame reader.
package p_ddr;
  localparam int P_ADDR_W         = 28;
  localparam int P_DATA_W         = 256;
  localparam int P_BYTES_PER_BEAT = 32;
  localparam int P_FRAME_W        = 20;
  localparam int P_FRAME_MAX      = (1 << P_FRAME_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DATA
  } state_e;
endpackage

// File: rtl/ddr_frame_rd_fsm.sv
// Burst request control: remaining-beat, address,
// beat and outstanding-credit tracking.
module frame_rd_fsm
  import p_ddr::*;
#(
  parameter int ADDR_W         = P_ADDR_W,
  parameter int BURST_MAX      = 4,
  parameter int BYTES_PER_BEAT = P_BYTES_PER_BEAT,
  parameter int FRAME_W        = P_FRAME_W,
  parameter int FIFO_CNT_W     = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  init_done_i,
  input  logic                  enable_i,
  input  logic [FRAME_W-1:0]    frame_beats_i,
  input  logic [ADDR_W-1:0]     base_i,
  input  logic [FIFO_CNT_W-1:0] fifo_free_i,
  input  logic                  rd_ack_i,
  input  logic                  rdata_valid_i,
  input  logic                  wr_i,
  output logic                  rd_req_o,
  output logic [ADDR_W-1:0]     adr_o,
  output logic [3:0]            arlen_o,
  output logic                  frame_start_o,
  output logic                  frame_done_o,
  output logic                  beat_o,
  output logic                  bnd_o
);
  localparam int BL_W  = 5;
  localparam int OUT_W = 6;

  state_e             state_q;
  logic [FRAME_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BL_W-1:0]    blen_c, blen_q, beat_q;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [3:0]         arlen_q;
  logic               rd_req_q, start_q, done_q;
  logic               first_q, fits_c, last_c;

  always_comb begin
    blen_c = (rem_q > FRAME_W'(BURST_MAX))
           ? BL_W'(BURST_MAX) : BL_W'(rem_q);
    // credits: beats requested but not yet
    // reflected in the FIFO free count
    fits_c = int'(fifo_free_i) >=
             int'(blen_c) + int'(out_q);
    beat_o = rdata_valid_i && (state_q == S_DATA);
    last_c = beat_o &&
             (beat_q + BL_W'(1) == blen_q);
    rem_d  = rem_q - FRAME_W'(blen_q);
    addr_d = addr_q + ADDR_W'(blen_q) *
             ADDR_W'(BYTES_PER_BEAT);
    bnd_o  = last_c && (rem_d == '0);
    out_d  = out_q;
    if (state_q == S_REQ && rd_ack_i)
      out_d = out_d + OUT_W'(blen_q);
    if (wr_i)
      out_d = out_d - OUT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      addr_q   <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      out_q    <= '0;
      arlen_q  <= '0;
      rd_req_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= out_d;
      unique case (state_q)
        S_IDLE: begin
          if (init_done_i && enable_i) begin
            // a zero count would never terminate
            rem_q   <= (frame_beats_i == '0)
                     ? FRAME_W'(1) : frame_beats_i;
            addr_q  <= base_i;
            first_q <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!init_done_i) begin
            state_q <= S_IDLE;
          end else if (fits_c) begin
            blen_q   <= blen_c;
            arlen_q  <= 4'(blen_c - BL_W'(1));
            rd_req_q <= 1'b1;
            start_q  <= first_q;
            first_q  <= 1'b0;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_ack_i) begin
            rd_req_q <= 1'b0;
            beat_q   <= '0;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (last_c) begin
            beat_q  <= '0;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            done_q  <= bnd_o;
            state_q <= (bnd_o || !init_done_i)
                     ? S_IDLE : S_CHECK;
          end else if (beat_o) begin
            beat_q <= beat_q + BL_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_req_o      = rd_req_q;
  assign adr_o         = addr_q;
  assign arlen_o       = arlen_q;
  assign frame_start_o = start_q;
  assign frame_done_o  = done_q;
endmodule

// File: rtl/ddr_frame_rd.sv
// DDR frame reader top: beat register, buffer
// swap bookkeeping and FIFO overflow flag.
module ddr_frame_rd
  import p_ddr::*;
#(
  parameter int ADDR_W         = P_ADDR_W,
  parameter int DATA_W         = P_DATA_W,
  parameter int PIX_W          = 240,
  parameter int BURST_MAX      = 4,
  parameter int BYTES_PER_BEAT = P_BYTES_PER_BEAT,
  parameter int NUM_FB         = 2,
  parameter int FB_W           = 2,
  parameter int FRAME_W        = P_FRAME_W,
  parameter int FIFO_CNT_W     = 6
) (
  input  logic                     ddr_clk,
  input  logic                     rstn,
  input  logic                     init_done,
  input  logic                     enable,
  input  logic [NUM_FB*ADDR_W-1:0] fb_base,
  input  logic [FRAME_W-1:0]       frame_beats,
  input  logic                     swap_req,
  input  logic [FB_W-1:0]          swap_idx,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        ddr_rd_adr,
  output logic [3:0]               arlen,
  input  logic                     rd_ack,
  input  logic [DATA_W-1:0]        ddr_rdata,
  input  logic                     rdata_valid,
  input  logic [FIFO_CNT_W-1:0]    fifo_free,
  output logic                     fifo_wr_en,
  output logic [PIX_W-1:0]         fifo_wdata,
  output logic [FB_W-1:0]          cur_fb,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     ovf_err
);
  logic              beat, bnd, swap_ok;
  logic              wr_q, pend_v_q, ovf_q;
  logic [PIX_W-1:0]  wdata_q;
  logic [FB_W-1:0]   cur_fb_q, pend_q;
  logic [ADDR_W-1:0] base;
  logic              unused_rdata;

  assign unused_rdata = ^ddr_rdata[DATA_W-1:PIX_W];

  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_FB; i++)
      if (cur_fb_q == FB_W'(i))
        base = fb_base[i*ADDR_W +: ADDR_W];
    swap_ok = swap_req &&
              (int'(swap_idx) < NUM_FB);
  end

  frame_rd_fsm #(
    .ADDR_W         (ADDR_W),
    .BURST_MAX      (BURST_MAX),
    .BYTES_PER_BEAT (BYTES_PER_BEAT),
    .FRAME_W        (FRAME_W),
    .FIFO_CNT_W     (FIFO_CNT_W)
  ) u_fsm (
    .clk_i         (ddr_clk),
    .rstn_i        (rstn),
    .init_done_i   (init_done),
    .enable_i      (enable),
    .frame_beats_i (frame_beats),
    .base_i        (base),
    .fifo_free_i   (fifo_free),
    .rd_ack_i      (rd_ack),
    .rdata_valid_i (rdata_valid),
    .wr_i          (wr_q),
    .rd_req_o      (rd_req),
    .adr_o         (ddr_rd_adr),
    .arlen_o       (arlen),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .beat_o        (beat),
    .bnd_o         (bnd)
  );

  always_ff @(posedge ddr_clk) begin
    if (!rstn) begin
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cur_fb_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_q <= beat;
      if (beat)
        wdata_q <= ddr_rdata[PIX_W-1:0];
      if (beat && fifo_free == '0)
        ovf_q <= 1'b1;
      // a request landing on the boundary wins
      if (bnd) begin
        if (swap_ok)
          cur_fb_q <= swap_idx;
        else if (pend_v_q)
          cur_fb_q <= pend_q;
        pend_v_q <= 1'b0;
      end else if (swap_ok) begin
        pend_q   <= swap_idx;
        pend_v_q <= 1'b1;
      end
    end
  end

  assign fifo_wr_en = wr_q;
  assign fifo_wdata = wdata_q;
  assign cur_fb     = cur_fb_q;
  assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_ddr_frame_rd.sv
// Scoreboard bench for ddr_frame_rd: DDR model
// pushes beats, FIFO-side monitor pops and compares.
module tb_ddr_frame_rd;
  localparam logic [27:0] FB0 = 28'h0100000;
  localparam logic [27:0] FB1 = 28'h0200000;

  typedef struct packed {
    logic [239:0] d;
    logic         last;
  } wr_t;

  logic         ddr_clk = 1'b0;
  logic         rstn, init_done, enable;
  logic [55:0]  fb_base;
  logic [19:0]  frame_beats;
  logic         swap_req;
  logic [1:0]   swap_idx;
  logic         rd_req, rd_ack;
  logic [27:0]  ddr_rd_adr;
  logic [3:0]   arlen;
  logic [255:0] ddr_rdata;
  logic         rdata_valid;
  logic [5:0]   fifo_free;
  logic         fifo_wr_en;
  logic [239:0] fifo_wdata;
  logic [1:0]   cur_fb;
  logic         frame_start, frame_done, ovf_err;

  int  checks = 0;
  int  errors = 0;
  int  nwr = 0;
  int  ndone = 0;
  int  cyc = 0;
  int  done_cyc = 0;
  bit  have_done = 0;
  wr_t exp_q[$];

  ddr_frame_rd dut (
    .ddr_clk     (ddr_clk),
    .rstn        (rstn),
    .init_done   (init_done),
    .enable      (enable),
    .fb_base     (fb_base),
    .frame_beats (frame_beats),
    .swap_req    (swap_req),
    .swap_idx    (swap_idx),
    .rd_req      (rd_req),
    .ddr_rd_adr  (ddr_rd_adr),
    .arlen       (arlen),
    .rd_ack      (rd_ack),
    .ddr_rdata   (ddr_rdata),
    .rdata_valid (rdata_valid),
    .fifo_free   (fifo_free),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wdata  (fifo_wdata),
    .cur_fb      (cur_fb),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .ovf_err     (ovf_err)
  );

  always #5 ddr_clk = ~ddr_clk;
  always @(posedge ddr_clk) cyc++;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // FIFO-side monitor
  always @(negedge ddr_clk) begin
    if (fifo_wr_en) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("wr_extra", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wdata", fifo_wdata, e.d);
        chk("fdone", frame_done, e.last);
      end
    end else if (frame_done) begin
      chk("fdone_stray", 1, 0);
    end
    if (frame_done) begin
      ndone++;
      done_cyc = cyc;
      have_done = 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ddr_clk);
    #1;
  endtask

  task automatic pulse_swap(input logic [1:0] i);
    @(posedge ddr_clk); #1;
    swap_req = 1'b1;
    swap_idx = i;
    @(posedge ddr_clk); #1;
    swap_req = 1'b0;
  endtask

  task automatic drive_beat(input bit push,
                            input bit last);
    rdata_valid = 1'b1;
    ddr_rdata = {8{$urandom()}};
    if (push)
      exp_q.push_back({ddr_rdata[239:0], last});
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rd_req"}, rd_req, 0);
    chk({p, "_adr"}, ddr_rd_adr, 0);
    chk({p, "_arlen"}, arlen, 0);
    chk({p, "_wr_en"}, fifo_wr_en, 0);
    chk({p, "_wdata"}, fifo_wdata, 0);
    chk({p, "_cur_fb"}, cur_fb, 0);
    chk({p, "_pulses"},
        {frame_start, frame_done}, 0);
    chk({p, "_ovf"}, ovf_err, 0);
  endtask

  // DDR model: one request, one ack, len+1 beats
  task automatic serve(input logic [27:0] adr,
                       input logic [3:0] len,
                       input bit first,
                       input bit lastb,
                       input bit stop,
                       input bit ovf);
    int n = 0;
    do begin
      @(negedge ddr_clk);
      n++;
    end while (!rd_req && n < 200);
    if (!rd_req) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("adr", ddr_rd_adr, adr);
    chk("arlen", arlen, len);
    chk("fstart", frame_start, first);
    if (first && have_done)
      chk("gap", (cyc - done_cyc >= 2), 1);
    @(posedge ddr_clk); #1;
    rd_ack = 1'b1;
    if (lastb && stop)
      enable = 1'b0;
    @(posedge ddr_clk); #1;
    rd_ack = 1'b0;
    if (ovf)
      fifo_free = '0;
    for (int b = 0; b <= int'(len); b++) begin
      drive_beat(1, lastb && b == int'(len));
      if (b == 0) begin
        @(negedge ddr_clk);
        chk("req_fall", rd_req, 0);
      end
      @(posedge ddr_clk); #1;
    end
    rdata_valid = 1'b0;
    fifo_free = 6'd63;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge ddr_clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    wait_cyc(3);
  endtask

  task automatic run_frame(input logic [27:0] base,
                           input int beats,
                           input bit stop,
                           input bit ovf);
    logic [27:0] a;
    int rem;
    bit first;
    a = base;
    rem = beats;
    first = 1;
    frame_beats = 20'(beats);
    enable = 1'b1;
    while (rem > 0) begin
      int bl;
      bl = (rem > 4) ? 4 : rem;
      serve(a, 4'(bl - 1), first, rem == bl,
            stop, ovf);
      a = a + 28'(bl * 32);
      rem -= bl;
      first = 0;
    end
    if (stop)
      drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, d0, n;
    bit seen;
    rstn = 1'b0;
    init_done = 1'b0;
    enable = 1'b0;
    fb_base = {FB1, FB0};
    frame_beats = 20'd0;
    swap_req = 1'b0;
    swap_idx = '0;
    rd_ack = 1'b0;
    ddr_rdata = '0;
    rdata_valid = 1'b0;
    fifo_free = 6'd63;
    repeat (3) @(posedge ddr_clk);
    @(negedge ddr_clk);
    chk_reset("rst");
    @(posedge ddr_clk); #1;
    rstn = 1'b1;
    init_done = 1'b1;

    // 10 beats: bursts 4,4,2
    n0 = nwr;
    d0 = ndone;
    run_frame(FB0, 10, 1, 0);
    chk("t1_nwr", nwr - n0, 10);
    chk("t1_ndone", ndone - d0, 1);

    // credit stall until free space covers blen
    fifo_free = 6'd3;
    frame_beats = 20'd4;
    enable = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge ddr_clk);
      if (rd_req) seen = 1;
    end
    chk("bp_hold", seen, 0);
    @(posedge ddr_clk); #1;
    fifo_free = 6'd4;
    run_frame(FB0, 4, 1, 0);
    fifo_free = 6'd63;

    // swaps applied only at frame boundaries
    fork
      run_frame(FB0, 10, 0, 0);
      begin
        wait_cyc(6);
        pulse_swap(2'd1);
        wait_cyc(2);
        chk("fb_hold0", cur_fb, 0);
      end
    join
    fork
      run_frame(FB1, 6, 0, 0);
      begin
        wait_cyc(4);
        chk("fb_now1", cur_fb, 1);
        pulse_swap(2'd1);
        pulse_swap(2'd0);
        chk("fb_hold1", cur_fb, 1);
      end
    join
    fork
      run_frame(FB0, 4, 1, 0);
      begin
        wait_cyc(3);
        pulse_swap(2'd2);
      end
    join
    chk("fb_ign", cur_fb, 0);

    // overflow flag is sticky
    chk("ovf_pre", ovf_err, 0);
    run_frame(FB0, 4, 1, 1);
    chk("ovf_set", ovf_err, 1);
    run_frame(FB0, 4, 1, 0);
    chk("ovf_sticky", ovf_err, 1);

    // address wraps at 2^28
    fb_base = {FB1, 28'hFFFFFE0};
    run_frame(28'hFFFFFE0, 5, 1, 0);
    fb_base = {FB1, FB0};

    // reset in the middle of a burst
    pulse_swap(2'd1);
    frame_beats = 20'd8;
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge ddr_clk);
      n++;
    end while (!rd_req && n < 100);
    chk("rst_req", {rd_req, ddr_rd_adr},
        {1'b1, FB0});
    @(posedge ddr_clk); #1;
    rd_ack = 1'b1;
    @(posedge ddr_clk); #1;
    rd_ack = 1'b0;
    drive_beat(1, 0);
    @(posedge ddr_clk); #1;
    drive_beat(1, 0);
    @(posedge ddr_clk); #1;
    drive_beat(0, 0);
    rstn = 1'b0;
    enable = 1'b0;
    @(posedge ddr_clk); #1;
    rstn = 1'b1;
    drive_beat(0, 0);
    @(negedge ddr_clk);
    chk_reset("mid");
    repeat (2) begin
      @(posedge ddr_clk); #1;
      drive_beat(0, 0);
    end
    @(posedge ddr_clk); #1;
    rdata_valid = 1'b0;
    wait_cyc(4);
    chk("rst_drain", exp_q.size(), 0);
    run_frame(FB0, 4, 1, 0);
    chk("pend_clr", cur_fb, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
